fp_div_sqrt_arbiter: RTL and testbench

Shares one iterative FP32 divide/square-root core among NUM_LANES FP issue lanes. It grants a reservation to one lane at a time using round-robin arbitration. It sequences the core through operand capture, start, completion and result hold, and absorbs selective flushes of the owning op. The block sits between the FP scheduler / FP execution lanes and the single div/sqrt core.

---
 rtl/fp_div_sqrt_arbiter.sv | 147 ++++++++++++++
 tb/tb_fp_div_sqrt_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sqrt_arbiter.sv
// Round-robin reservation arbiter that shares one iterative FP32 div/sqrt core
// among several FP issue lanes, sequencing capture, start, completion and flushes.
module fp_div_sqrt_arbiter #(
    parameter int NUM_LANES    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int RM_WIDTH     = 3,
    parameter int FFLAGS_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LANES-1:0]             reserve_req_i,
    output logic [NUM_LANES-1:0]             reserved_o,
    input  logic [NUM_LANES-1:0]             req_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  data_a_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  data_b_i,
    input  logic [NUM_LANES-1:0]             is_divide_i,
    input  logic [NUM_LANES*RM_WIDTH-1:0]    rm_i,
    input  logic [NUM_LANES-1:0]             flush_i,
    input  logic [NUM_LANES-1:0]             release_i,
    output logic                             core_start_o,
    output logic [DATA_WIDTH-1:0]            core_a_o,
    output logic [DATA_WIDTH-1:0]            core_b_o,
    output logic                             core_is_divide_o,
    output logic [RM_WIDTH-1:0]              core_rm_o,
    input  logic                             core_done_i,
    input  logic [DATA_WIDTH-1:0]            core_result_i,
    input  logic [FFLAGS_WIDTH-1:0]          core_fflags_i,
    output logic [NUM_LANES-1:0]             finished_o,
    output logic [DATA_WIDTH-1:0]            result_o,
    output logic [FFLAGS_WIDTH-1:0]          fflags_o
);

    localparam int OW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RESERVED,
        BUSY,
        DONE,
        DRAIN
    } state_t;

    state_t          state, state_nx;
    logic [OW-1:0]   owner, owner_nx;
    logic [OW-1:0]   last_grant, last_grant_nx;
    logic [OW-1:0]   grant_idx, cand;
    logic            grant_found;
    logic            capture, latch_res, start_q;
    logic [NUM_LANES-1:0] owner_onehot;

    // Search starts one past the last winner so every lane gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        cand        = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = OW'((int'(last_grant) + i) % NUM_LANES);
            if (!grant_found && reserve_req_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        capture       = 1'b0;
        latch_res     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    owner_nx      = grant_idx;
                    last_grant_nx = grant_idx;
                    state_nx      = RESERVED;
                end
            end
            RESERVED: begin
                if (flush_i[owner]) begin
                    state_nx = IDLE;
                end else if (req_i[owner]) begin
                    capture  = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // A flush racing the completion wins: the result is simply dropped.
                if (core_done_i && flush_i[owner]) begin
                    state_nx = IDLE;
                end else if (core_done_i) begin
                    latch_res = 1'b1;
                    state_nx  = DONE;
                end else if (flush_i[owner]) begin
                    state_nx = DRAIN;
                end
            end
            DONE: begin
                if (release_i[owner] || flush_i[owner]) begin
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                if (core_done_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            owner            <= '0;
            last_grant       <= OW'(NUM_LANES - 1);
            start_q          <= 1'b0;
            core_a_o         <= '0;
            core_b_o         <= '0;
            core_is_divide_o <= 1'b0;
            core_rm_o        <= '0;
            result_o         <= '0;
            fflags_o         <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            start_q    <= capture;
            if (capture) begin
                core_a_o         <= data_a_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
                core_b_o         <= data_b_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
                core_is_divide_o <= is_divide_i[owner];
                core_rm_o        <= rm_i[int'(owner)*RM_WIDTH +: RM_WIDTH];
            end
            if (latch_res) begin
                result_o <= core_result_i;
                fflags_o <= core_fflags_i;
            end
        end
    end

    assign owner_onehot = NUM_LANES'(1) << owner;
    assign reserved_o   = (state == RESERVED || state == BUSY || state == DONE) ? owner_onehot : '0;
    assign finished_o   = (state == DONE) ? owner_onehot : '0;
    assign core_start_o = start_q;

endmodule

// File: tb/tb_fp_div_sqrt_arbiter.sv
// Self-checking bench for fp_div_sqrt_arbiter: directed scenarios with random
// operands, checked against a round-robin and latched-value reference model.
module tb_fp_div_sqrt_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reserve_req_i, reserved_o, req_i, is_divide_i, flush_i, release_i, finished_o;
    logic [63:0] data_a_i, data_b_i;
    logic [5:0]  rm_i;
    logic        core_start_o, core_is_divide_o, core_done_i;
    logic [31:0] core_a_o, core_b_o, core_result_i, result_o;
    logic [2:0]  core_rm_o;
    logic [4:0]  core_fflags_i, fflags_o;

    int total = 0;
    int bad   = 0;

    // Reference model: last winning lane plus the values the DUT must be holding.
    int          last_grant;
    logic [31:0] m_a, m_b, m_res;
    logic        m_div;
    logic [2:0]  m_rm;
    logic [4:0]  m_ff;
    int          lane;
    logic [1:0]  own;

    fp_div_sqrt_arbiter dut (
        .clk(clk), .rst(rst),
        .reserve_req_i(reserve_req_i), .reserved_o(reserved_o),
        .req_i(req_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
        .is_divide_i(is_divide_i), .rm_i(rm_i),
        .flush_i(flush_i), .release_i(release_i),
        .core_start_o(core_start_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
        .core_is_divide_o(core_is_divide_o), .core_rm_o(core_rm_o),
        .core_done_i(core_done_i), .core_result_i(core_result_i), .core_fflags_i(core_fflags_i),
        .finished_o(finished_o), .result_o(result_o), .fflags_o(fflags_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rrPick(input logic [1:0] reqs);
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (last_grant + k) % 2;
            if (reqs[c]) return c;
        end
        return -1;
    endfunction

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_core_a"}, core_a_o, m_a);
        checkOutput({tag, "_core_b"}, core_b_o, m_b);
        checkOutput({tag, "_core_div"}, 32'(core_is_divide_o), 32'(m_div));
        checkOutput({tag, "_core_rm"}, 32'(core_rm_o), 32'(m_rm));
        checkOutput({tag, "_result"}, result_o, m_res);
        checkOutput({tag, "_fflags"}, 32'(fflags_o), 32'(m_ff));
    endtask

    // Grant, then one cycle of noise on non-owner lanes that must be ignored.
    task automatic grantOnly(input logic [1:0] reqs);
        lane = rrPick(reqs);
        own  = 2'(1 << lane);
        reserve_req_i = reqs;
        tick();
        reserve_req_i = 2'b00;
        last_grant = lane;
        checkOutput("grant", 32'(reserved_o), 32'(own));
        checkOutput("grant_no_finish", 32'(finished_o), 0);
        req_i = ~own; flush_i = ~own; release_i = ~own;
        tick();
        req_i = 2'b00; flush_i = 2'b00; release_i = 2'b00;
        checkOutput("hold_reserved", 32'(reserved_o), 32'(own));
        checkOutput("no_start_yet", 32'(core_start_o), 0);
    endtask

    task automatic grantAndIssue(input logic [1:0] reqs, input logic [31:0] a, input logic [31:0] b,
                                 input logic div, input logic [2:0] rm);
        grantOnly(reqs);
        data_a_i = {$urandom(), $urandom()};
        data_b_i = {$urandom(), $urandom()};
        is_divide_i = 2'($urandom());
        rm_i = 6'($urandom());
        data_a_i[lane*32 +: 32] = a;
        data_b_i[lane*32 +: 32] = b;
        is_divide_i[lane] = div;
        rm_i[lane*3 +: 3] = rm;
        m_a = a; m_b = b; m_div = div; m_rm = rm;
        req_i = own;
        tick();
        req_i = 2'b00;
        checkOutput("start_pulse", 32'(core_start_o), 1);
        checkOutput("busy_reserved", 32'(reserved_o), 32'(own));
        checkHeld("capture");
    endtask

    task automatic applyStimulus(input logic [1:0] reqs, input int latency,
                                 input logic [31:0] a, input logic [31:0] b, input logic div,
                                 input logic [2:0] rm, input logic [31:0] res, input logic [4:0] ff);
        grantAndIssue(reqs, a, b, div, rm);
        for (int c = 1; c < latency; c++) begin
            tick();
            checkOutput("start_once", 32'(core_start_o), 0);
            checkOutput("busy_no_finish", 32'(finished_o), 0);
        end
        core_done_i = 1'b1; core_result_i = res; core_fflags_i = ff;
        tick();
        core_done_i = 1'b0; core_result_i = $urandom(); core_fflags_i = 5'($urandom());
        m_res = res; m_ff = ff;
        checkOutput("finished", 32'(finished_o), 32'(own));
        checkOutput("done_reserved", 32'(reserved_o), 32'(own));
        checkHeld("done");
        release_i = ~own; flush_i = ~own;
        tick();
        release_i = 2'b00; flush_i = 2'b00;
        checkOutput("finished_hold", 32'(finished_o), 32'(own));
        checkOutput("result_hold", result_o, m_res);
        release_i = own;
        tick();
        release_i = 2'b00;
        checkOutput("idle_reserved", 32'(reserved_o), 0);
        checkOutput("idle_finished", 32'(finished_o), 0);
    endtask

    initial begin
        rst = 1'b1;
        reserve_req_i = '0; req_i = '0; is_divide_i = '0; flush_i = '0; release_i = '0;
        data_a_i = '0; data_b_i = '0; rm_i = '0;
        core_done_i = 1'b0; core_result_i = '0; core_fflags_i = '0;
        last_grant = 1; m_a = '0; m_b = '0; m_div = 1'b0; m_rm = '0; m_res = '0; m_ff = '0;
        lane = 0; own = 2'b01;
        repeat (2) tick();
        checkOutput("rst_reserved", 32'(reserved_o), 0);
        checkOutput("rst_finished", 32'(finished_o), 0);
        checkOutput("rst_start", 32'(core_start_o), 0);
        checkHeld("rst");
        rst = 1'b0;
        tick();

        $display("[TB] directed divide on lane 0");
        applyStimulus(2'b01, 10, 32'h40400000, 32'h3f800000, 1'b1, 3'd0, 32'h40400000, 5'h00);

        $display("[TB] alternating grants with both lanes requesting");
        for (int n = 0; n < 4; n++) begin
            applyStimulus(2'b11, $urandom_range(1, 6), $urandom(), $urandom(), 1'($urandom()),
                          3'($urandom()), $urandom(), 5'($urandom()));
            checkOutput("alternation", 32'(lane), 32'((n + 1) % 2));
        end

        $display("[TB] flush while reserved");
        grantOnly(2'b11);
        flush_i = own; req_i = own;
        tick();
        flush_i = 2'b00; req_i = 2'b00;
        checkOutput("rsv_flush_reserved", 32'(reserved_o), 0);
        checkOutput("rsv_flush_no_start", 32'(core_start_o), 0);
        checkHeld("rsv_flush");

        $display("[TB] flush while busy then drain");
        grantAndIssue(2'b11, $urandom(), $urandom(), 1'b0, 3'($urandom()));
        flush_i = own;
        tick();
        flush_i = 2'b00;
        reserve_req_i = 2'b11;
        for (int c = 0; c < 4; c++) begin
            checkOutput("drain_reserved", 32'(reserved_o), 0);
            checkOutput("drain_finished", 32'(finished_o), 0);
            tick();
        end
        core_done_i = 1'b1; core_result_i = $urandom(); core_fflags_i = 5'($urandom());
        tick();
        core_done_i = 1'b0;
        checkOutput("drain_end_reserved", 32'(reserved_o), 0);
        checkOutput("drain_end_finished", 32'(finished_o), 0);
        checkHeld("drain_discard");
        lane = rrPick(2'b11);
        own  = 2'(1 << lane);
        last_grant = lane;
        tick();
        checkOutput("post_drain_grant", 32'(reserved_o), 32'(own));
        reserve_req_i = 2'b00; flush_i = own;
        tick();
        flush_i = 2'b00;
        checkOutput("post_drain_flush", 32'(reserved_o), 0);

        $display("[TB] flush and done together");
        grantAndIssue(2'b11, $urandom(), $urandom(), 1'b1, 3'($urandom()));
        tick();
        flush_i = own; core_done_i = 1'b1; core_result_i = ~m_res; core_fflags_i = ~m_ff;
        tick();
        flush_i = 2'b00; core_done_i = 1'b0;
        checkOutput("race_reserved", 32'(reserved_o), 0);
        checkOutput("race_finished", 32'(finished_o), 0);
        checkHeld("race");
        tick();
        checkOutput("race_finished_later", 32'(finished_o), 0);

        $display("[TB] asynchronous reset while busy");
        grantAndIssue(2'b11, $urandom(), $urandom(), 1'b1, 3'($urandom()));
        tick();
        rst = 1'b1;
        #1;
        last_grant = 1; m_a = '0; m_b = '0; m_div = 1'b0; m_rm = '0; m_res = '0; m_ff = '0;
        checkOutput("arst_reserved", 32'(reserved_o), 0);
        checkOutput("arst_finished", 32'(finished_o), 0);
        checkOutput("arst_start", 32'(core_start_o), 0);
        checkHeld("arst");
        tick();
        rst = 1'b0;
        core_done_i = 1'b1; core_result_i = $urandom(); core_fflags_i = 5'($urandom());
        tick();
        core_done_i = 1'b0;
        checkOutput("late_done_finished", 32'(finished_o), 0);
        checkOutput("late_done_result", result_o, 0);
        applyStimulus(2'b11, 3, $urandom(), $urandom(), 1'b0, 3'($urandom()), $urandom(), 5'($urandom()));
        checkOutput("reset_priority", 32'(lane), 0);

        $display("[TB] random request patterns");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(2'($urandom_range(1, 3)), $urandom_range(1, 8), $urandom(), $urandom(),
                          1'($urandom()), 3'($urandom()), $urandom(), 5'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
